// File: rtl/sr_ctl_pkg.sv
// Shared opcode constants, controller state encoding and the expected-Q helper
// for the SR flip-flop bank controller.
package sr_ctl_pkg;

    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_SET = 2'b01;
    localparam logic [1:0] OP_CLR = 2'b10;
    localparam logic [1:0] OP_TOG = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PULSE  = 2'd1,
        ST_SETTLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Q level the flip-flop must show once the command has settled.
    // For TOG the current level is also what picks S or R.
    function automatic logic exp_q(input logic [1:0] op, input logic q_now);
        logic v;
        case (op)
            OP_SET:  v = 1'b1;
            OP_CLR:  v = 1'b0;
            OP_TOG:  v = ~q_now;
            default: v = 1'b0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; remembers the last requester granted and
// gives the other one priority when both ask at once.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_req,
    input  logic       i_update,
    output logic [1:0] o_grant
);

    // Reset value marks B as last granted so A wins the first tie.
    logic r_last_b;

    always_comb begin
        o_grant = 2'b00;
        case (i_req)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11:   o_grant = r_last_b ? 2'b01 : 2'b10;
            default: o_grant = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_b <= 1'b1;
        end else if (i_update && (o_grant != 2'b00)) begin
            r_last_b <= o_grant[1];
        end
    end

endmodule

// File: rtl/sr_bank_ctrl.sv
// Sequences a bank of external SR flip-flops for two round-robin requesters:
// one-hot S/R pulse, settle window, Q check, per-requester ack.
module sr_bank_ctrl
    import sr_ctl_pkg::*;
#(
    parameter int N          = 8,
    parameter int IDX_W      = 3,
    parameter int PULSE_CYC  = 1,
    parameter int SETTLE_CYC = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_a_req,
    input  logic [1:0]       i_a_op,
    input  logic [IDX_W-1:0] i_a_idx,
    output logic             o_a_ack,
    input  logic             i_b_req,
    input  logic [1:0]       i_b_op,
    input  logic [IDX_W-1:0] i_b_idx,
    output logic             o_b_ack,
    input  logic [N-1:0]     i_q,
    output logic [N-1:0]     o_s,
    output logic [N-1:0]     o_r,
    output logic             o_busy,
    output logic             o_err,
    output logic [IDX_W-1:0] o_err_idx,
    input  logic             i_err_clr
);

    localparam int CNT_MAX = (PULSE_CYC > SETTLE_CYC) ? PULSE_CYC : SETTLE_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [IDX_W:0] LP_N   = (IDX_W + 1)'(N);
    localparam logic [N-1:0]   LP_ONE = {{(N-1){1'b0}}, 1'b1};

    state_t           r_state;
    logic             r_sel_b;
    logic [1:0]       r_op;
    logic [IDX_W-1:0] r_idx;
    logic             r_oor;
    logic             r_exp;
    logic [CNT_W-1:0] r_cnt;

    logic [1:0]       w_grant;
    logic             w_update;
    logic [1:0]       w_op;
    logic [IDX_W-1:0] w_idx;
    logic             w_oor;
    logic             w_q_now;
    logic             w_exp_now;
    logic             w_q_done;
    logic             w_mismatch;

    assign w_update = (r_state == ST_IDLE);

    rr_arb2 u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_req    ({i_b_req, i_a_req}),
        .i_update (w_update),
        .o_grant  (w_grant)
    );

    // Command of whichever requester the arbiter picks this cycle.
    assign w_op      = w_grant[1] ? i_b_op  : i_a_op;
    assign w_idx     = w_grant[1] ? i_b_idx : i_a_idx;
    assign w_oor     = ({1'b0, w_idx} >= LP_N);
    assign w_q_now   = w_oor ? 1'b0 : i_q[w_idx];
    assign w_exp_now = exp_q(w_op, w_q_now);

    assign w_q_done   = r_oor ? 1'b0 : i_q[r_idx];
    assign w_mismatch = r_oor || ((r_op != OP_NOP) && (w_q_done != r_exp));

    assign o_busy = (r_state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_sel_b   <= 1'b0;
            r_op      <= OP_NOP;
            r_idx     <= '0;
            r_oor     <= 1'b0;
            r_exp     <= 1'b0;
            r_cnt     <= '0;
            o_s       <= '0;
            o_r       <= '0;
            o_a_ack   <= 1'b0;
            o_b_ack   <= 1'b0;
            o_err     <= 1'b0;
            o_err_idx <= '0;
        end else begin
            o_s     <= '0;
            o_r     <= '0;
            o_a_ack <= 1'b0;
            o_b_ack <= 1'b0;

            // A detected mismatch takes precedence over a same-cycle clear.
            if ((r_state == ST_DONE) && w_mismatch) begin
                o_err     <= 1'b1;
                o_err_idx <= r_idx;
            end else if (i_err_clr) begin
                o_err <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_grant != 2'b00) begin
                        r_sel_b <= w_grant[1];
                        r_op    <= w_op;
                        r_idx   <= w_idx;
                        r_oor   <= w_oor;
                        r_exp   <= w_exp_now;
                        if ((w_op == OP_NOP) || w_oor) begin
                            r_state <= ST_DONE;
                            o_a_ack <= w_grant[0];
                            o_b_ack <= w_grant[1];
                        end else begin
                            r_state <= ST_PULSE;
                            r_cnt   <= CNT_W'(PULSE_CYC - 1);
                            if (w_exp_now) begin
                                o_s <= LP_ONE << w_idx;
                            end else begin
                                o_r <= LP_ONE << w_idx;
                            end
                        end
                    end
                end
                ST_PULSE: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_SETTLE;
                        r_cnt   <= CNT_W'(SETTLE_CYC - 1);
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                        o_s   <= o_s;
                        o_r   <= o_r;
                    end
                end
                ST_SETTLE: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_DONE;
                        o_a_ack <= ~r_sel_b;
                        o_b_ack <= r_sel_b;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/sr_bank_ctrl.md
Name: sr_bank_ctrl

Overview:
Controller that sequences a bank of N external SR flip-flops shared by two requesters, A and B. It arbitrates between A and B round-robin. It turns SET, CLR, TOG and NOP commands into timed, one-hot S or R pulses, and never drives S and R high together. After a settle window it checks the flip-flop Q feedback and returns a per-requester ack.

Parameters:
N, 8, number of SR flip-flops in the bank
IDX_W, 3, index width, at least clog2(N)
PULSE_CYC, 1, cycles each S/R pulse is held high (1 or more)
SETTLE_CYC, 2, idle cycles after a pulse before Q is checked (1 or more)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous, active-low reset
a_req  in  1  requester A command request, level
a_op  in  2  requester A opcode
a_idx  in  IDX_W  requester A target flip-flop
a_ack  out  1  requester A completion pulse (1 cycle)
b_req  in  1  requester B command request, level
b_op  in  2  requester B opcode
b_idx  in  IDX_W  requester B target flip-flop
b_ack  out  1  requester B completion pulse (1 cycle)
q_i  in  N  Q feedback from the flip-flop bank
s_o  out  N  set drive, at most one bit high
r_o  out  N  reset drive, at most one bit high
busy  out  1  high while not in IDLE
err  out  1  sticky error flag
err_idx  out  IDX_W  index of the most recent error
err_clr  in  1  synchronous clear of err

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low. While rst_n=0, all outputs are 0 (s_o, r_o, acks, busy, err, err_idx), the state is IDLE and the round-robin pointer favours A.
- States: IDLE, PULSE, SETTLE, DONE.
- IDLE: samples a_req/b_req.
  - Only one asserted: that requester is granted.
  - Both asserted: the requester not granted last wins.
  - On grant: latch op and idx. For TOG, also latch q_i[idx] sampled that cycle.
  - Next state is PULSE, or DONE for NOP or out-of-range idx.
- Opcode encoding: SET=2'b01 drives S; CLR=2'b10 drives R; TOG=2'b11 drives R if latched q was 1, else S; NOP=2'b00 drives nothing.
- Expected Q: 1 for SET, 0 for CLR, the inverse of latched q for TOG.
- PULSE: exactly one of s_o[idx] or r_o[idx] is high for PULSE_CYC cycles, then SETTLE. s_o and r_o are registered outputs.
- SETTLE: s_o = r_o = 0 for SETTLE_CYC cycles, then DONE.
- DONE (one cycle):
  - Granted requester's ack = 1.
  - For SET/CLR/TOG, compare q_i[idx] with expected Q. On mismatch: err <= 1, err_idx <= idx.
  - Round-robin pointer moves to the other requester; next state IDLE.
- Out-of-range idx (idx ≥ N): no pulse. In DONE, ack is issued and err <= 1, err_idx <= idx.
- Latency: a request sampled in IDLE at edge 0 acks at cycle PULSE_CYC+SETTLE_CYC+1 (4 with defaults). NOP acks at cycle 1. The earliest next grant is sampled the cycle after ack.
- Requester rules:
  - Hold req/op/idx stable until ack.
  - Changes to op/idx after the grant are ignored.
  - Dropping req mid-operation does not abort it; ack is still issued.
  - req still high in the cycle after ack counts as a new request, subject to round-robin.
- err_clr and a mismatch in the same cycle: set wins. err_clr in any other cycle clears err; err_idx is kept.
- busy = (state != IDLE).
- Reset mid-operation: s_o/r_o drop immediately (asynchronous), no ack is issued, and the latched command is discarded.
- Invariant: (s_o | r_o) is zero or one-hot, and s_o & r_o == 0, in every cycle.

Decomposition:
- Shared include/package sr_ctl_pkg: opcode constants OP_NOP/OP_SET/OP_CLR/OP_TOG and the state encodings ST_IDLE/ST_PULSE/ST_SETTLE/ST_DONE.
- Sub-module rr_arb2: two-input round-robin arbiter.
  - Inputs: req[1:0], update strobe.
  - Output: one-hot grant[1:0].
  - Holds the last-granted pointer, which resets to favour A.

Test Plan:
- Reset and SET: rst_n low, then A req SET idx=3 with the bank modelled as SR flip-flops -> s_o=8'h08 for 1 cycle; a_ack at cycle 4; q_i[3]=1; err=0.
- Simultaneous requests: A CLR idx=0 and B SET idx=7, both from reset -> A served first (r_o=8'h01), then B (s_o=8'h80). With both held continuously, grants alternate A, B, A, B.
- TOG twice on idx=5 starting from q=0 -> first toggle drives s_o[5], second drives r_o[5]; final q_i[5]=0; 2 acks.
- Fault: bank model sticks q_i[2]=0, A SET idx=2 -> a_ack at cycle 4, err=1, err_idx=2. err_clr pulse then clears err.
- NOP and out-of-range (N=6): NOP -> ack at cycle 1 with no pulse. idx=7 -> ack, no pulse, err=1, err_idx=7.
- Reset mid-PULSE with PULSE_CYC=3: rst_n low in the 2nd pulse cycle -> s_o=0 immediately, no ack, busy=0. Every cycle of every test checks s_o & r_o == 0.
